mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 8, words per line transfer (power of 2, 2..16).
REQ-002 SHALL have parameter DELAY_BITS, default 4, matching the main memory latency counter width (documentation/bench only; no RTL dependence).
REQ-003 SHALL have port MEM_CLK  in  1  single clock, all logic on posedge.
REQ-004 SHALL have port RST  in  1  synchronous active-high reset.
REQ-005 SHALL have ports IC_REQ in 1 (I-cache line read request) and IC_ADDR in 30 (word address; low log2(LINE_WORDS) bits ignored).
REQ-006 SHALL have ports IC_DATA out 32, IC_WORD_VALID out 1, IC_WORD_IDX out log2(LINE_WORDS), IC_DONE out 1.
REQ-007 SHALL have ports DC_REQ in 1, DC_WE in 1 (1 = line write-back, 0 = line fill), DC_ADDR in 30, DC_WDATA in 32 (word selected by DC_WORD_IDX).
REQ-008 SHALL have ports DC_RDATA out 32, DC_WORD_VALID out 1, DC_WORD_IDX out log2(LINE_WORDS), DC_DONE out 1.
REQ-009 SHALL have memory-side ports MEM_RE out 1, MEM_WE out 1, MEM_ADDR out 30, MEM_DATA_IN out 32, MEM_DOUT in 32, memValid in 1.

Function
REQ-010 SHALL implement FSM states IDLE, IC_XFER, DC_XFER.
REQ-011 IDLE: MEM_RE=0, MEM_WE=0, MEM_ADDR=0, MEM_DATA_IN=0, all VALID/DONE=0.
REQ-012 IDLE, only IC_REQ=1 -> IC_XFER next edge; only DC_REQ=1 -> DC_XFER next edge; neither -> stay IDLE.
REQ-013 IDLE, both requests -> grant opposite of last_grant register (round-robin); last_grant updated on every grant.
REQ-014 On grant, line base address (request address with low log2(LINE_WORDS) bits zeroed) and DC_WE SHALL be latched; word index counter cleared to 0.
REQ-015 IC_XFER: MEM_RE=1, MEM_WE=0, MEM_ADDR = line base | index, combinationally from registered state.
REQ-016 DC_XFER: MEM_RE = ~latched_we, MEM_WE = latched_we, MEM_ADDR = line base | index, MEM_DATA_IN = DC_WDATA.
REQ-017 MEM_RE/MEM_WE SHALL stay continuously high for the whole line; the address changes only on the edge where memValid=1.
REQ-018 Word completes in any XFER cycle with memValid=1: granted side's WORD_VALID=1 (combinational), WORD_IDX = current index, RDATA/DATA = MEM_DOUT (read only); index increments on that edge.
REQ-019 WORD_IDX SHALL output the current index throughout the granted transfer, 0 when not granted; non-granted side VALID/DONE SHALL stay 0.
REQ-020 Last word (index = LINE_WORDS-1 with memValid=1): DONE=1 same cycle, index wraps to 0, FSM -> IDLE next edge.
REQ-021 Requester SHALL drop REQ on the edge where it samples DONE=1; REQ still high in IDLE is treated as a new request.
REQ-022 REQ, ADDR, DC_WE changes during XFER SHALL be ignored; DC_REQ deasserted mid-transfer does not abort it.
REQ-023 memValid while IDLE SHALL be ignored (no VALID, no state change).
REQ-024 Timing, DELAY_BITS=4, LINE_WORDS=8: REQ seen in IDLE cycle t; XFER from t+1; word i valid at t+16+16i; DONE at t+128; IDLE at t+129.
REQ-025 Minimum one IDLE cycle between consecutive line transfers.
REQ-026 Write data SHALL be held stable by the D-cache for the indicated index; write commits at memory negedge while memValid=1.

Reset
REQ-027 RST=1 at posedge: state IDLE, index 0, latched address 0, latched_we 0, last_grant = DC (I-cache wins first tie).
REQ-028 Outputs after reset edge SHALL equal REQ-011 values.
REQ-029 RST mid-transfer SHALL abort next edge with no DONE pulse; already-written words remain; requester must reissue.
REQ-030 RST has priority over memValid and any request in the same cycle.

Verification
REQ-031 IC_REQ=1, IC_ADDR=0x0000_0105 -> MEM_ADDR 0x100..0x107, IC_WORD_VALID at t+16,32..128, IC_DONE at t+128 with idx 7.
REQ-032 DC_REQ=1, DC_WE=1, DC_ADDR=0x40, DC_WDATA=0xA5A5_0000+idx -> MEM_WE high 128 cycles, memory words 0x40..0x47 = A5A50000..A5A50007, MEM_RE=0 throughout.
REQ-033 IC_REQ and DC_REQ both raised in same cycle after reset, held after DONE for a second line -> I line first, then D line, then I; one IDLE cycle between.
REQ-034 DC fill in progress, IC_REQ raised at word 3 -> no IC_WORD_VALID until DC_DONE; IC granted after one IDLE cycle.
REQ-035 RST pulsed at word 4 of DC write-back -> MEM_WE=0 next cycle, DC_DONE never asserted, words 0x40..0x43 written, 0x44..0x47 unchanged.
REQ-036 memValid forced high while IDLE -> no VALID/DONE, state stays IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin I-cache/D-cache line-transfer arbiter in front of main memory
// One line (LINE_WORDS words) per grant; the word index advances only on memValid.
module mem_arbiter #(
   parameter int LINE_WORDS = 8,
   parameter int DELAY_BITS = 4
) (
   input  logic                          MEM_CLK,
   input  logic                          RST,
   input  logic                          IC_REQ,
   input  logic [29:0]                   IC_ADDR,
   output logic [31:0]                   IC_DATA,
   output logic                          IC_WORD_VALID,
   output logic [$clog2(LINE_WORDS)-1:0] IC_WORD_IDX,
   output logic                          IC_DONE,
   input  logic                          DC_REQ,
   input  logic                          DC_WE,
   input  logic [29:0]                   DC_ADDR,
   input  logic [31:0]                   DC_WDATA,
   output logic [31:0]                   DC_RDATA,
   output logic                          DC_WORD_VALID,
   output logic [$clog2(LINE_WORDS)-1:0] DC_WORD_IDX,
   output logic                          DC_DONE,
   output logic                          MEM_RE,
   output logic                          MEM_WE,
   output logic [29:0]                   MEM_ADDR,
   output logic [31:0]                   MEM_DATA_IN,
   input  logic [31:0]                   MEM_DOUT,
   input  logic                          memValid
);

   localparam int          IDX_W    = $clog2(LINE_WORDS);
   localparam logic [29:0] IDX_MASK = 30'(LINE_WORDS - 1);

   if (LINE_WORDS < 2 || LINE_WORDS > 16 || DELAY_BITS < 1) begin : g_param_check
      $error("mem_arbiter: unsupported LINE_WORDS/DELAY_BITS");
   end

   typedef enum logic [1:0] {IDLE, IC_XFER, DC_XFER} state_t;

   state_t             state;
   state_t             next_state;
   logic [IDX_W-1:0]   word_idx;
   logic [29:0]        line_base;
   logic               latched_we;
   logic               last_grant;   // 1 = D-cache received the most recent grant
   logic               last_word;
   logic [29:0]        cur_addr;

   assign last_word = (word_idx == IDX_W'(LINE_WORDS - 1));
   assign cur_addr  = line_base | 30'(word_idx);

   always_ff @(posedge MEM_CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (IC_REQ && DC_REQ) begin
               next_state = last_grant ? IC_XFER : DC_XFER;
            end else if (IC_REQ) begin
               next_state = IC_XFER;
            end else if (DC_REQ) begin
               next_state = DC_XFER;
            end
         end
         IC_XFER, DC_XFER: begin
            if (memValid && last_word) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Request inputs are only sampled in IDLE; during a transfer they are ignored.
   always_ff @(posedge MEM_CLK) begin
      if (RST) begin
         word_idx   <= '0;
         line_base  <= '0;
         latched_we <= 1'b0;
         last_grant <= 1'b1;
      end else if (state == IDLE) begin
         word_idx <= '0;
         if (next_state == IC_XFER) begin
            line_base  <= IC_ADDR & ~IDX_MASK;
            latched_we <= 1'b0;
            last_grant <= 1'b0;
         end else if (next_state == DC_XFER) begin
            line_base  <= DC_ADDR & ~IDX_MASK;
            latched_we <= DC_WE;
            last_grant <= 1'b1;
         end
      end else if (memValid) begin
         word_idx <= word_idx + 1'b1;
      end
   end

   always_comb begin
      MEM_RE        = 1'b0;
      MEM_WE        = 1'b0;
      MEM_ADDR      = '0;
      MEM_DATA_IN   = '0;
      IC_DATA       = '0;
      IC_WORD_VALID = 1'b0;
      IC_WORD_IDX   = '0;
      IC_DONE       = 1'b0;
      DC_RDATA      = '0;
      DC_WORD_VALID = 1'b0;
      DC_WORD_IDX   = '0;
      DC_DONE       = 1'b0;
      case (state)
         IC_XFER: begin
            MEM_RE        = 1'b1;
            MEM_ADDR      = cur_addr;
            IC_WORD_IDX   = word_idx;
            IC_WORD_VALID = memValid;
            IC_DONE       = memValid && last_word;
            IC_DATA       = memValid ? MEM_DOUT : '0;
         end
         DC_XFER: begin
            MEM_RE        = ~latched_we;
            MEM_WE        = latched_we;
            MEM_ADDR      = cur_addr;
            MEM_DATA_IN   = DC_WDATA;
            DC_WORD_IDX   = word_idx;
            DC_WORD_VALID = memValid;
            DC_DONE       = memValid && last_word;
            DC_RDATA      = (memValid && !latched_we) ? MEM_DOUT : '0;
         end
         default: ;
      endcase
   end

endmodule
